// File: rtl/apb_timeout_guard.sv
// apb_timeout_guard: APB pass-through stage that ends transfers stalled by a hung slave with PSLVERR
module apb_timeout_guard #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      clear_i,
  input  logic [APB_ADDR_WIDTH-1:0] s_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s_pwdata,
  input  logic                      s_pwrite,
  input  logic                      s_psel,
  input  logic                      s_penable,
  output logic [APB_DATA_WIDTH-1:0] s_prdata,
  output logic                      s_pready,
  output logic                      s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] m_paddr,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata,
  output logic                      m_pwrite,
  output logic                      m_psel,
  output logic                      m_penable,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr,
  output logic                      timeout_o,
  output logic [15:0]               err_count_o,
  output logic [APB_ADDR_WIDTH-1:0] err_addr_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic resp;
  assign resp      = state == RESP;
  assign m_paddr   = s_paddr;
  assign m_pwdata  = s_pwdata;
  assign m_pwrite  = s_pwrite;
  assign m_psel    = s_psel & ~resp;
  assign m_penable = s_penable & ~resp;
  assign s_prdata  = resp ? '0 : m_prdata;
  assign s_pready  = resp | m_pready;
  assign s_pslverr = resp | m_pslverr;
  // error registers latch during the RESP cycle so they read back one cycle after it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_o   <= 1'b0;
      err_count_o <= '0;
      err_addr_o  <= '0;
    end else begin
      timeout_o   <= 1'b0;
      err_count_o <= resp ? (clear_i ? 16'd1 : err_count_o + 16'(err_count_o != 16'hFFFF))
                          : (clear_i ? '0 : err_count_o);
      err_addr_o  <= resp ? s_paddr : (clear_i ? '0 : err_addr_o);
      case (state)
        IDLE:
          if (s_psel && s_penable && !m_pready && en_i) begin
            state <= WAIT;
            cnt   <= CNT_WIDTH'(1);
          end else cnt <= '0;
        WAIT:
          if (!s_psel || m_pready) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (en_i && cnt == LAST) begin
            state     <= RESP;
            cnt       <= '0;
            timeout_o <= 1'b1;
          end else if (en_i) cnt <= cnt + CNT_WIDTH'(1);
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule
